if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// if_stage: instruction fetch with a 2-entry {pc,instr} FIFO toward decode.
// Ports: clk, rst (sync, active-high); imem_req/imem_addr out,
// imem_rvalid/imem_rdata in (1-cycle latency); ifid_valid/ifid_pc/ifid_instr
// out with id_ready in; redirect_valid/redirect_pc in; fetch_fault out.
// Optional macro IF_MISALIGN_CHECK_EN: a misaligned redirect halts fetch
// and raises a sticky fetch_fault; otherwise redirect_pc[1:0] is ignored.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_instr,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);

    typedef enum logic {FETCH, HALT} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic [31:0] ins0_q, ins0_d, ins1_q, ins1_d;
    logic        inflight_q, inflight_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic        drop_q, drop_d;
    logic        fault_q, fault_d;

    logic        pop;
    logic        push;
    logic        redir;
    logic        mis;
    logic [2:0]  occ;
    logic [31:0] tgt;

`ifdef IF_MISALIGN_CHECK_EN
    assign mis = (redirect_pc[1:0] != 2'b00);
`else
    logic unused_lsb;
    assign unused_lsb = ^redirect_pc[1:0];
    assign mis = 1'b0;
`endif

    assign tgt   = {redirect_pc[31:2], 2'b00};
    assign redir = !rst && redirect_valid && (state_q == FETCH);

    assign ifid_valid = !rst && (cnt_q != 2'd0);
    assign ifid_pc    = rst ? 32'h0 : pc0_q;
    assign ifid_instr = rst ? 32'h0 : ins0_q;
    assign pop        = ifid_valid && id_ready;

    // Only responses to a live, non-flushed request may enter the FIFO.
    assign push = imem_rvalid && inflight_q && !drop_q;

    // Slots already owed: held entries plus the pending response, less
    // the one leaving this cycle. Request only if a slot stays free.
    assign occ = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

    assign imem_req  = !rst && (state_q == FETCH) && !redir && (occ <= 3'd1);
    assign imem_addr = pc_q;

`ifdef IF_MISALIGN_CHECK_EN
    assign fetch_fault = !rst && fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        pc0_d      = pc0_q;
        pc1_d      = pc1_q;
        ins0_d     = ins0_q;
        ins1_d     = ins1_q;
        inflight_d = imem_req;
        ifpc_d     = ifpc_q;
        drop_d     = redir;
        fault_d    = fault_q;

        if (imem_req) begin
            ifpc_d = pc_q;
            pc_d   = pc_q + 32'd4;
        end

        if (redir) begin
            // Flush wins over any push/pop/stall this cycle.
            cnt_d = 2'd0;
            pc_d  = tgt;
            if (mis) begin
                state_d = HALT;
                fault_d = 1'b1;
            end
        end else begin
            unique case ({push, pop})
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        pc0_d  = ifpc_q;
                        ins0_d = imem_rdata;
                    end else begin
                        pc0_d  = pc1_q;
                        ins0_d = ins1_q;
                        pc1_d  = ifpc_q;
                        ins1_d = imem_rdata;
                    end
                end
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        pc0_d  = ifpc_q;
                        ins0_d = imem_rdata;
                    end else begin
                        pc1_d  = ifpc_q;
                        ins1_d = imem_rdata;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    pc0_d  = pc1_q;
                    ins0_d = ins1_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            cnt_q      <= 2'd0;
            pc0_q      <= 32'h0;
            pc1_q      <= 32'h0;
            ins0_q     <= 32'h0;
            ins1_q     <= 32'h0;
            inflight_q <= 1'b0;
            ifpc_q     <= 32'h0;
            drop_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            pc0_q      <= pc0_d;
            pc1_q      <= pc1_d;
            ins0_q     <= ins0_d;
            ins1_q     <= ins1_d;
            inflight_q <= inflight_d;
            ifpc_q     <= ifpc_d;
            drop_q     <= drop_d;
            fault_q    <= fault_d;
        end
    end

endmodule
